uart_frame_parser: RTL and testbench

Byte-stream frame parser placed directly downstream of the UART receiver. It consumes the receiver's `op_data`/`op_flag` byte strobes and recognises frames of the form HEAD0, HEAD1, LEN, payload[LEN], CSUM. Payload bytes are streamed out with a one-cycle latency, and a good/bad verdict pulse is issued per frame. An inter-byte timeout resynchronises the parser when a frame stalls.

---
 rtl/uart_frame_parser.sv | 150 +++++++++++++++
 tb/tb_uart_frame_parser.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - UART byte-stream frame parser with checksum verdict and inter-byte timeout
module uart_frame_parser #(
    parameter logic [7:0]  HEAD0       = 8'h55,
    parameter logic [7:0]  HEAD1       = 8'hAA,
    parameter logic [7:0]  MAX_LEN     = 8'd16,
    parameter logic [31:0] TIMEOUT_CYC = 32'd50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_flag,
    input  logic [7:0] op_data,
    output logic [7:0] pl_data,
    output logic       pl_flag,
    output logic       pl_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_LEN,
        S_DATA,
        S_CSUM
    } state_t;

    localparam logic [31:0] TMO_LAST = TIMEOUT_CYC - 32'd1;

    state_t      state, state_nxt;
    logic [7:0]  len_q, len_nxt;
    logic [7:0]  cnt_q, cnt_nxt;
    logic [7:0]  csum_q, csum_nxt;
    logic [31:0] tmo_q, tmo_nxt;
    logic [7:0]  pl_data_nxt;
    logic        pl_flag_nxt;
    logic        pl_last_nxt;
    logic        frame_ok_nxt;
    logic        frame_err_nxt;
    logic [1:0]  err_code_nxt;
    logic [7:0]  frame_cnt_nxt;
    logic        tmo_hit;

    // A stalled frame expires only when no byte arrives on the terminal-count cycle.
    assign tmo_hit = (state != S_IDLE) && !op_flag && (tmo_q == TMO_LAST);

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            csum_q    <= 8'd0;
            tmo_q     <= 32'd0;
            pl_data   <= 8'd0;
            pl_flag   <= 1'b0;
            pl_last   <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            len_q     <= len_nxt;
            cnt_q     <= cnt_nxt;
            csum_q    <= csum_nxt;
            tmo_q     <= tmo_nxt;
            pl_data   <= pl_data_nxt;
            pl_flag   <= pl_flag_nxt;
            pl_last   <= pl_last_nxt;
            frame_ok  <= frame_ok_nxt;
            frame_err <= frame_err_nxt;
            err_code  <= err_code_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

    // Next-state, timeout and output decode; the timeout only wins when no byte is present.
    always_comb begin
        state_nxt     = state;
        len_nxt       = len_q;
        cnt_nxt       = cnt_q;
        csum_nxt      = csum_q;
        tmo_nxt       = 32'd0;
        pl_data_nxt   = pl_data;
        pl_flag_nxt   = 1'b0;
        pl_last_nxt   = 1'b0;
        frame_ok_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        err_code_nxt  = err_code;
        frame_cnt_nxt = frame_cnt;

        if (state != S_IDLE && !op_flag) begin
            tmo_nxt = tmo_q + 32'd1;
        end

        if (tmo_hit) begin
            state_nxt     = S_IDLE;
            tmo_nxt       = 32'd0;
            frame_err_nxt = 1'b1;
            err_code_nxt  = 2'b11;
        end else if (op_flag) begin
            case (state)
                S_IDLE: begin
                    if (op_data == HEAD0) state_nxt = S_HEAD;
                end
                S_HEAD: begin
                    if (op_data == HEAD1)      state_nxt = S_LEN;
                    else if (op_data == HEAD0) state_nxt = S_HEAD;
                    else                       state_nxt = S_IDLE;
                end
                S_LEN: begin
                    if (op_data != 8'd0 && op_data <= MAX_LEN) begin
                        len_nxt   = op_data;
                        csum_nxt  = op_data;
                        cnt_nxt   = 8'd0;
                        state_nxt = S_DATA;
                    end else begin
                        frame_err_nxt = 1'b1;
                        err_code_nxt  = 2'b01;
                        state_nxt     = S_IDLE;
                    end
                end
                S_DATA: begin
                    pl_data_nxt = op_data;
                    pl_flag_nxt = 1'b1;
                    csum_nxt    = csum_q + op_data;
                    cnt_nxt     = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == len_q) begin
                        pl_last_nxt = 1'b1;
                        state_nxt   = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (op_data == csum_q) begin
                        frame_ok_nxt  = 1'b1;
                        frame_cnt_nxt = frame_cnt + 8'd1;
                    end else begin
                        frame_err_nxt = 1'b1;
                        err_code_nxt  = 2'b10;
                    end
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - randomized frame-level bench for uart_frame_parser
module tb_uart_frame_parser;

    localparam int TMO = 100;

    logic       clk;
    logic       rst_n;
    logic       op_flag;
    logic [7:0] op_data;
    logic [7:0] pl_data;
    logic       pl_flag;
    logic       pl_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] frame_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] got_w[$];
    int          got_c[$];
    logic [31:0] exp_w[$];
    int          exp_c[$];

    logic [7:0] m_pl;
    logic [1:0] m_code;
    logic [7:0] m_cnt;
    logic [7:0] pay[0:255];

    uart_frame_parser #(
        .HEAD0      (8'h55),
        .HEAD1      (8'hAA),
        .MAX_LEN    (8'd16),
        .TIMEOUT_CYC(32'd100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_flag  (op_flag),
        .op_data  (op_data),
        .pl_data  (pl_data),
        .pl_flag  (pl_flag),
        .pl_last  (pl_last),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code),
        .frame_cnt(frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Observed output events, stamped with the cycle they were seen in.
    always @(negedge clk) begin
        if (rst_n && (pl_flag || frame_ok || frame_err)) begin
            check("excl", 32'(pl_flag) + 32'(frame_ok) + 32'(frame_err), 32'd1);
            got_w.push_back({10'd0, pl_flag, frame_ok, frame_err, pl_data, pl_last, err_code, frame_cnt});
            got_c.push_back(cyc);
        end
    end

    task automatic push_pay(input logic [7:0] b, input logic last, input int oc);
        m_pl = b;
        exp_w.push_back({10'd0, 3'b100, b, last, m_code, m_cnt});
        exp_c.push_back(oc);
    endtask

    task automatic push_ok(input int oc);
        m_cnt = m_cnt + 8'd1;
        exp_w.push_back({10'd0, 3'b010, m_pl, 1'b0, m_code, m_cnt});
        exp_c.push_back(oc);
    endtask

    task automatic push_err(input logic [1:0] code, input int oc);
        m_code = code;
        exp_w.push_back({10'd0, 3'b001, m_pl, 1'b0, m_code, m_cnt});
        exp_c.push_back(oc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one byte for one cycle; oc is the cycle its response must appear in.
    task automatic drive(input logic [7:0] b, output int oc);
        op_flag = 1'b1;
        op_data = b;
        @(posedge clk);
        #1;
        op_flag = 1'b0;
        oc = cyc;
    endtask

    task automatic flush(input string tag);
        int n;
        idle(3);
        check({tag, "_nev"}, got_w.size(), exp_w.size());
        n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_ev%0d", tag, i), got_w[i], exp_w[i]);
            check($sformatf("%s_cyc%0d", tag, i), got_c[i], exp_c[i]);
        end
        got_w.delete(); got_c.delete(); exp_w.delete(); exp_c.delete();
    endtask

    // Frame 55 AA LEN payload CSUM; delta corrupts the checksum, nsend truncates the frame.
    task automatic send_frame(input int len, input bit rnd, input int delta, input int nsend, input int gapmax);
        logic [7:0] b[$];
        int sum;
        int oc;
        bit badlen;
        badlen = (len < 1) || (len > 16);
        b.push_back(8'h55);
        b.push_back(8'hAA);
        b.push_back(len[7:0]);
        sum = len;
        if (!badlen) begin
            for (int i = 0; i < len; i++) begin
                if (rnd) pay[i] = 8'($urandom);
                b.push_back(pay[i]);
                sum += int'(pay[i]);
            end
        end
        b.push_back(8'(sum + delta));
        oc = 0;
        for (int i = 0; i < nsend && i < b.size(); i++) begin
            if (gapmax > 0) idle($urandom_range(0, gapmax));
            drive(b[i], oc);
            if (i == 2 && badlen) push_err(2'b01, oc);
            else if (i >= 3 && i < 3 + len) push_pay(b[i], i == 2 + len, oc);
            else if (i == 3 + len) begin
                if (delta % 256 == 0) push_ok(oc);
                else push_err(2'b10, oc);
            end
        end
        if (!badlen && nsend < len + 4) begin
            push_err(2'b11, oc + TMO);
            idle(TMO + 10);
        end
    endtask

    initial begin
        int oc;
        int kind;
        int len;
        logic [7:0] nb;
        m_pl = 8'd0; m_code = 2'b00; m_cnt = 8'd0;
        rst_n = 1'b0;
        op_flag = 1'b0;
        op_data = 8'd0;
        idle(3);
        check("rst_pl_data", pl_data, 0);
        check("rst_pl_flag", pl_flag, 0);
        check("rst_pl_last", pl_last, 0);
        check("rst_ok", frame_ok, 0);
        check("rst_err", frame_err, 0);
        check("rst_code", err_code, 0);
        check("rst_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        idle(2);

        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(3, 0, 0, 7, 0);
        flush("good");
        check("good_cnt", frame_cnt, 1);

        pay[0] = 8'h01; pay[1] = 8'h02;
        send_frame(2, 0, -1, 6, 0);
        flush("badsum");
        check("badsum_code", err_code, 2'b10);

        send_frame(0, 0, 0, 3, 0);
        send_frame(17, 0, 0, 3, 0);
        pay[0] = 8'h5A;
        send_frame(1, 0, 0, 5, 1);
        flush("badlen");

        pay[0] = 8'h01; pay[1] = 8'h02;
        send_frame(2, 0, 0, 4, 0);
        pay[0] = 8'h7E;
        send_frame(1, 0, 0, 5, 0);
        flush("tmo");

        drive(8'h55, oc); drive(8'hAA, oc); drive(8'h02, oc);
        drive(8'h01, oc); push_pay(8'h01, 1'b0, oc);
        idle(TMO - 1);
        drive(8'h02, oc); push_pay(8'h02, 1'b1, oc);
        drive(8'h05, oc); push_ok(oc);
        flush("tc_hold");

        drive(8'h55, oc); drive(8'hAA, oc); drive(8'h02, oc);
        drive(8'h01, oc); push_pay(8'h01, 1'b0, oc);
        push_err(2'b11, oc + TMO);
        idle(TMO);
        drive(8'h02, oc);
        flush("tc_late");

        drive(8'h55, oc);
        pay[0] = 8'h7E;
        send_frame(1, 0, 0, 5, 0);
        flush("resync");

        drive(8'h55, oc); drive(8'hAA, oc); drive(8'h03, oc);
        drive(8'h11, oc); push_pay(8'h11, 1'b0, oc);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_pl_data", pl_data, 0);
        check("mid_pl_flag", pl_flag, 0);
        check("mid_pl_last", pl_last, 0);
        check("mid_ok", frame_ok, 0);
        check("mid_err", frame_err, 0);
        check("mid_code", err_code, 0);
        check("mid_cnt", frame_cnt, 0);
        m_pl = 8'd0; m_code = 2'b00; m_cnt = 8'd0;
        flush("midrst");
        rst_n = 1'b1;
        idle(2);
        pay[0] = 8'hC3; pay[1] = 8'h3C; pay[2] = 8'hFF;
        send_frame(3, 0, 0, 7, 0);
        flush("postrst");
        check("postrst_cnt", frame_cnt, 1);

        for (int f = 0; f < 255; f++) begin
            len = $urandom_range(1, 16);
            send_frame(len, 1, 0, len + 4, 1);
        end
        flush("wrap");
        check("wrap_cnt", frame_cnt, 0);

        for (int f = 0; f < 120; f++) begin
            kind = $urandom_range(0, 3);
            len = $urandom_range(1, 16);
            if ($urandom_range(0, 3) == 0) begin
                nb = 8'($urandom);
                if (nb == 8'h55) nb = 8'h00;
                drive(nb, oc);
            end
            case (kind)
                0: send_frame(len, 1, 0, len + 4, 2);
                1: send_frame(len, 1, $urandom_range(1, 255), len + 4, 2);
                2: send_frame(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255), 1, 0, 3, 2);
                default: send_frame(len, 1, 0, $urandom_range(1, len + 3), 2);
            endcase
        end
        flush("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
